// File: rtl/nios_oci_mem_ctrl.sv
// Debug-side memory controller for the Nios II OCI block: owns a 256x32 debug RAM and
// arbitrates JTAG host accesses (jdo + take_*_ocimem_* strobes) against an Avalon-MM CPU slave.
module nios_oci_mem_ctrl #(
  parameter int          RAM_AW        = 8,
  parameter logic [31:0] RESET_MONDREG = 32'h0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [RAM_AW-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun,
  output logic [2:0]        debug_state
);

  // Avalon handshake: a CPU transfer completes in the cycle where avs_read or avs_write is
  // high and avs_waitrequest is low; read data is valid in that same cycle. With no request
  // present, avs_waitrequest is low.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_JRD1 = 3'd1,
    S_JRD2 = 3'd2,
    S_JWR1 = 3'd3,
    S_CRD1 = 3'd4,
    S_CRD2 = 3'd5
  } state_t;

  typedef enum logic {
    OP_JRD = 1'b0,
    OP_JWR = 1'b1
  } op_t;

  state_t            state, state_next, phase;
  logic              pend_valid;
  op_t               pend_op;
  logic [RAM_AW-1:0] mon_a;
  logic [31:0]       wbuf;
  logic [31:0]       rdata_q;
  logic              ready_pend;

  logic [31:0]       mem [2**RAM_AW];
  logic [31:0]       ram_q;
  logic              ram_rd;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;

  logic any_strobe, multi_strobe, jtag_busy, accept;
  logic post_op, load_addr, ready_arm;
  op_t  post_kind, go_kind;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Strobe decode. Priority b > a > no_action_a; extra strobes only flag an overrun.
  always_comb begin
    any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    multi_strobe = (take_action_ocimem_a & take_no_action_ocimem_a)
                 | (take_action_ocimem_a & take_action_ocimem_b)
                 | (take_no_action_ocimem_a & take_action_ocimem_b);
    jtag_busy    = pend_valid || (state inside {S_JRD1, S_JRD2, S_JWR1});
    accept       = any_strobe && !jtag_busy;
    post_op      = 1'b0;
    post_kind    = OP_JRD;
    load_addr    = 1'b0;
    ready_arm    = 1'b0;
    if (accept) begin
      if (take_action_ocimem_b) begin
        post_op   = 1'b1;
        post_kind = OP_JWR;
      end else if (take_action_ocimem_a) begin
        load_addr = 1'b1;
        if (jdo[17]) post_op = 1'b1;
        else         ready_arm = 1'b1;
      end else begin
        post_op = 1'b1;
      end
    end
  end

  // Next state, RAM port mux and waitrequest. The IDLE cycle that grants a CPU read
  // already issues the RAM read, so it is reported as CRD1 on debug_state.
  always_comb begin
    state_next      = state;
    phase           = state;
    ram_rd          = 1'b0;
    ram_we          = 1'b0;
    ram_be          = 4'h0;
    ram_addr        = mon_a;
    ram_wdata       = wbuf;
    avs_waitrequest = 1'b0;
    go_kind         = pend_valid ? pend_op : post_kind;
    case (state)
      S_IDLE: begin
        if (pend_valid || post_op) begin
          state_next = (go_kind == OP_JWR) ? S_JWR1 : S_JRD1;
        end else if (avs_read) begin
          phase      = S_CRD1;
          ram_rd     = 1'b1;
          ram_addr   = avs_address;
          state_next = S_CRD2;
        end
        // A CPU write shares the cycle with a freshly posted JTAG op: the op only needs
        // the RAM port from the next cycle on.
        if (avs_write && !avs_read && !pend_valid) begin
          ram_we    = 1'b1;
          ram_be    = avs_byteenable;
          ram_addr  = avs_address;
          ram_wdata = avs_writedata;
        end
        avs_waitrequest = avs_read || (avs_write && pend_valid);
      end
      S_JRD1: begin
        ram_rd          = 1'b1;
        state_next      = S_JRD2;
        avs_waitrequest = avs_read || avs_write;
      end
      S_JRD2: begin
        state_next      = S_IDLE;
        avs_waitrequest = avs_read || avs_write;
      end
      S_JWR1: begin
        ram_we          = 1'b1;
        ram_be          = 4'hF;
        state_next      = S_IDLE;
        avs_waitrequest = avs_read || avs_write;
      end
      S_CRD2: begin
        state_next      = S_IDLE;
        avs_waitrequest = avs_write;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign debug_state  = phase;
  assign avs_readdata = (state == S_CRD2) ? ram_q : rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      pend_valid    <= 1'b0;
      pend_op       <= OP_JRD;
      mon_a         <= '0;
      wbuf          <= 32'h0;
      rdata_q       <= 32'h0;
      MonDReg       <= RESET_MONDREG;
      monitor_ready <= 1'b0;
      ready_pend    <= 1'b0;
      jtag_overrun  <= 1'b0;
    end else begin
      state <= state_next;

      // Ops accepted in IDLE dispatch directly; only a CPU read in progress parks one here.
      if (state == S_IDLE) begin
        pend_valid <= 1'b0;
      end else if (post_op) begin
        pend_valid <= 1'b1;
        pend_op    <= post_kind;
      end

      if (accept && take_action_ocimem_b) wbuf <= jdo[34:3];

      if (load_addr)                                mon_a <= jdo[18 +: RAM_AW];
      else if (state == S_JRD2 || state == S_JWR1)  mon_a <= mon_a + 1'b1;

      if (state == S_JRD2) MonDReg <= ram_q;
      if (state == S_CRD2) rdata_q <= ram_q;

      ready_pend <= ready_arm;
      if (accept)                                                  monitor_ready <= 1'b0;
      else if (state == S_JRD2 || state == S_JWR1 || ready_pend)  monitor_ready <= 1'b1;

      if (any_strobe && (jtag_busy || multi_strobe)) jtag_overrun <= 1'b1;
    end
  end

  // Single-port RAM, synchronous read; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    if (ram_rd) ram_q <= mem[ram_addr];
  end

endmodule

// File: tb/tb_nios_oci_mem_ctrl.sv
// Self-checking bench for nios_oci_mem_ctrl: transaction-level model of the debug RAM,
// the JTAG address register and the JTAG-visible outputs, compared every cycle.
module tb_nios_oci_mem_ctrl;

  localparam int K_SET = 0;  // take_action_ocimem_a, jdo[17]=0
  localparam int K_RDA = 1;  // take_action_ocimem_a, jdo[17]=1
  localparam int K_RDN = 2;  // take_no_action_ocimem_a
  localparam int K_WR  = 3;  // take_action_ocimem_b

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, tn_a, ta_b;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] mon_dreg;
  logic        monitor_ready, jtag_overrun;
  logic [2:0]  debug_state;

  always #5 clk = ~clk;

  nios_oci_mem_ctrl #(.RAM_AW(8), .RESET_MONDREG(32'h0)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (tn_a),
    .take_action_ocimem_b    (ta_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (mon_dreg),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun),
    .debug_state             (debug_state)
  );

  // ---------------- model and scoreboard ----------------
  logic [31:0] mem_m [256];
  logic [7:0]  mon_a_m;
  logic [31:0] exp_mon;
  logic        exp_rdy, exp_ovr;
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mon_dreg", mon_dreg, exp_mon);
      check("monitor_ready", {31'b0, monitor_ready}, {31'b0, exp_rdy});
      check("jtag_overrun", {31'b0, jtag_overrun}, {31'b0, exp_ovr});
      if (!avs_read && !avs_write)
        check("waitreq_no_req", {31'b0, avs_waitrequest}, 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One JTAG strobe; 'extra' is added latency when the op has to wait behind a CPU read.
  task automatic jtag_op(input int kind, input logic [7:0] addr, input logic [31:0] data,
                         input int extra);
    int lat;
    jdo = {6'($urandom), $urandom};
    if (kind == K_WR) begin
      jdo[34:3] = data;
      ta_b = 1'b1;
    end else if (kind == K_RDN) begin
      tn_a = 1'b1;
    end else begin
      jdo[25:18] = addr;
      jdo[17]    = (kind == K_RDA);
      ta_a = 1'b1;
    end
    lat = ((kind == K_WR || kind == K_SET) ? 2 : 3) + extra;
    tick();
    ta_a = 1'b0; tn_a = 1'b0; ta_b = 1'b0;
    exp_rdy = 1'b0;
    if (kind == K_SET || kind == K_RDA) mon_a_m = addr;
    repeat (lat - 1) tick();
    if (kind == K_WR) begin
      mem_m[mon_a_m] = data;
      mon_a_m++;
    end else if (kind != K_SET) begin
      exp_mon = mem_m[mon_a_m];
      mon_a_m++;
    end
    exp_rdy = 1'b1;
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    avs_address = addr; avs_writedata = data; avs_byteenable = be; avs_write = 1'b1;
    @(negedge clk);
    check("cpu_wr_wait", {31'b0, avs_waitrequest}, 32'h0);
    for (int i = 0; i < 4; i++) if (be[i]) mem_m[addr][8*i +: 8] = data[8*i +: 8];
    tick();
    avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] addr, input int exp_waits, output logic [31:0] data);
    int waits = 0;
    avs_address = addr; avs_read = 1'b1;
    exp_q.push_back(mem_m[addr]);
    forever begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      waits++;
      if (waits > 40) begin
        checks++; errors++;
        $display("FAIL cpu_rd_timeout: got %0d waits expected %0d", waits, exp_waits);
        break;
      end
      tick();
    end
    data = avs_readdata;
    check("cpu_rd_data", data, exp_q.pop_front());
    check("cpu_rd_waits", 32'(waits), 32'(exp_waits));
    tick();
    avs_read = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic [7:0]  ra, rb;
    reset_n = 1'b0; jdo = '0; ta_a = 1'b0; tn_a = 1'b0; ta_b = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0; avs_byteenable = '0;
    exp_mon = 32'h0; exp_rdy = 1'b0; exp_ovr = 1'b0; mon_a_m = 8'h0;
    repeat (3) tick();
    reset_n = 1'b1;
    check("rst_mondreg", mon_dreg, 32'h0);
    check("rst_ready", {31'b0, monitor_ready}, 32'h0);
    check("rst_overrun", {31'b0, jtag_overrun}, 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    chk_en = 1'b1;

    for (int a = 0; a < 256; a++) cpu_write(8'(a), $urandom, 4'hF);

    // JTAG write then read back
    jtag_op(K_SET, 8'h10, 32'h0, 0);
    jtag_op(K_WR, 8'h0, 32'hDEADBEEF, 0);
    jtag_op(K_RDA, 8'h10, 32'h0, 0);
    check("lit_deadbeef", mon_dreg, 32'hDEADBEEF);
    check("lit_ready", {31'b0, monitor_ready}, 32'h1);

    // Auto-increment and wrap
    jtag_op(K_SET, 8'hFF, 32'h0, 0);
    jtag_op(K_WR, 8'h0, 32'h1, 0);
    jtag_op(K_WR, 8'h0, 32'h2, 0);
    jtag_op(K_RDA, 8'hFF, 32'h0, 0);
    check("lit_wrap_ff", mon_dreg, 32'h1);
    jtag_op(K_RDN, 8'h0, 32'h0, 0);
    check("lit_wrap_00", mon_dreg, 32'h2);

    // CPU byte enables
    cpu_write(8'h20, 32'h11223344, 4'hF);
    cpu_write(8'h20, 32'hAABBCCDD, 4'b0101);
    cpu_read(8'h20, 1, rd);
    check("lit_byteen", rd, 32'h11BB33DD);

    // Arbitration: JTAG read and CPU read in the same cycle
    fork
      jtag_op(K_RDA, 8'hFF, 32'h0, 0);
      cpu_read(8'h20, 4, rd);
    join
    check("lit_arb_cpu", rd, 32'h11BB33DD);
    check("lit_arb_jtag", mon_dreg, 32'h1);

    // JTAG strobe while the CPU read is in its data cycle
    fork
      cpu_read(8'h20, 1, rd);
      begin tick(); jtag_op(K_RDA, 8'h10, 32'h0, 1); end
    join

    // Strobe together with a granted CPU write
    fork
      cpu_write(8'h30, 32'h0BADF00D, 4'hF);
      jtag_op(K_WR, 8'h0, 32'h12345678, 0);
    join

    // Overrun: second strobe one cycle after the first
    fork
      jtag_op(K_RDA, 8'h10, 32'h0, 0);
      begin
        tick();
        tn_a = 1'b1;
        tick();
        tn_a = 1'b0;
        exp_ovr = 1'b1;
      end
    join
    check("lit_ovr_first_op", mon_dreg, 32'hDEADBEEF);
    jtag_op(K_RDN, 8'h0, 32'h0, 0);

    // Reset during JRD1
    jdo = '0; jdo[25:18] = 8'h10; jdo[17] = 1'b1; ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    exp_rdy = 1'b0; mon_a_m = 8'h10;
    reset_n = 1'b0;
    exp_mon = 32'h0; exp_ovr = 1'b0; mon_a_m = 8'h0;
    #1;
    check("midrst_mondreg", mon_dreg, 32'h0);
    check("midrst_ready", {31'b0, monitor_ready}, 32'h0);
    check("midrst_overrun", {31'b0, jtag_overrun}, 32'h0);
    check("midrst_readdata", avs_readdata, 32'h0);
    check("midrst_waitreq", {31'b0, avs_waitrequest}, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (3) tick();
    jtag_op(K_RDN, 8'h0, 32'h0, 0);
    check("lit_rst_addr0", mon_dreg, 32'h2);
    jtag_op(K_RDA, 8'h10, 32'h0, 0);
    check("lit_rst_keep", mon_dreg, 32'hDEADBEEF);

    // Two strobes in one cycle: b wins, overrun flagged
    jdo = {6'($urandom), $urandom}; jdo[34:3] = 32'hCAFE0001; ta_b = 1'b1; tn_a = 1'b1;
    tick();
    ta_b = 1'b0; tn_a = 1'b0;
    exp_rdy = 1'b0; exp_ovr = 1'b1;
    tick();
    mem_m[mon_a_m] = 32'hCAFE0001; mon_a_m++; exp_rdy = 1'b1;
    jtag_op(K_RDA, 8'h11, 32'h0, 0);
    check("lit_multi_strobe", mon_dreg, 32'hCAFE0001);

    // Randomized mix
    for (int n = 0; n < 250; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 7))
        0: jtag_op(K_SET, ra, 32'h0, 0);
        1: jtag_op(K_RDA, ra, 32'h0, 0);
        2: jtag_op(K_RDN, 8'h0, 32'h0, 0);
        3: jtag_op(K_WR, 8'h0, $urandom, 0);
        4: cpu_write(ra, $urandom, 4'($urandom));
        5: cpu_read(ra, 1, rd);
        6: fork
             cpu_read(ra, 1, rd);
             begin tick(); jtag_op(K_RDA, rb, 32'h0, 1); end
           join
        default: fork
             cpu_write(ra, $urandom, 4'($urandom));
             jtag_op(K_WR, 8'h0, $urandom, 0);
           join
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (2) tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nios_oci_mem_ctrl.md
# nios_oci_mem_ctrl

Debug-side memory controller for the Nios II on-chip instrumentation (OCI) block. It sits directly downstream of the JTAG debug-slave wrapper and consumes that wrapper's system-clock-domain `jdo` word and `take_action_ocimem_*` / `take_no_action_ocimem_a` strobes. It owns a 256x32 debug RAM and arbitrates between JTAG host accesses and CPU accesses arriving through an Avalon-MM slave port. It returns read data and status to the wrapper on `MonDReg` and `monitor_ready`.

## Interface
- `RAM_AW`, 8: debug RAM word-address width; depth is 2^RAM_AW.
- `RESET_MONDREG`, 32'h0: reset value of `MonDReg`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, rising-edge.
- `reset_n` in 1: asynchronous active-low reset.
- `jdo` in 38: JTAG data word, valid whenever any strobe is high.
- `take_action_ocimem_a` in 1: 1-cycle strobe; load address, optionally read.
- `take_no_action_ocimem_a` in 1: 1-cycle strobe; sequential read at the current address.
- `take_action_ocimem_b` in 1: 1-cycle strobe; write at the current address.
- `avs_address` in RAM_AW: CPU word address.
- `avs_read` / `avs_write` in 1: CPU read and write requests.
- `avs_writedata` in 32: CPU write data.
- `avs_byteenable` in 4: CPU byte lanes.
- `avs_readdata` out 32: CPU read data.
- `avs_waitrequest` out 1: CPU stall.
- `MonDReg` out 32: JTAG-side data register, fed back to the debug slave.
- `monitor_ready` out 1: last JTAG operation is complete.
- `jtag_overrun` out 1: sticky; a strobe was dropped.

## Operation
- `MonAReg` is an internal RAM_AW-bit JTAG address register.
- `jdo` field map:
  - `jdo[25:18]`: address.
  - `jdo[17]`: read-enable for `take_action_ocimem_a`.
  - `jdo[34:3]`: write data.
- `take_action_ocimem_a`:
  - Loads `MonAReg <= jdo[25:18]` and clears `monitor_ready`.
  - If `jdo[17]=1`, posts pending op JRD; otherwise sets `monitor_ready` on the next edge.
- `take_no_action_ocimem_a`: posts JRD at `MonAReg` and clears `monitor_ready`.
- `take_action_ocimem_b`: captures `jdo[34:3]` into a write buffer, posts JWR and clears `monitor_ready`. The write is full-word.
- Pending register is one deep. A strobe arriving while an op is pending or executing is dropped and sets `jtag_overrun`. Only reset clears `jtag_overrun`. More than one strobe in the same cycle counts as an overrun; the strobe priority order is b, a, no_action_a.
- FSM states:
  - IDLE:
    - A pending JTAG op has priority. JRD -> JRD1; JWR -> JWR1.
    - Otherwise `avs_read` -> CRD1.
    - Otherwise `avs_write` is completed in IDLE itself: byte-masked write, `waitrequest=0`, stays in IDLE.
  - JRD1: RAM read issued at `MonAReg` -> JRD2.
  - JRD2: `MonDReg <=` RAM data; `monitor_ready <= 1`; `MonAReg <= MonAReg+1`; -> IDLE.
  - JWR1: RAM written with the buffer; `monitor_ready <= 1`; `MonAReg <= MonAReg+1`; -> IDLE.
  - CRD1: RAM read at `avs_address`, `waitrequest=1` -> CRD2.
  - CRD2: `avs_readdata <=` RAM data, `waitrequest=0` -> IDLE.
- `MonAReg` increments modulo 2^RAM_AW, so 8'hFF wraps to 8'h00.
- `avs_waitrequest` is 1 whenever a CPU request is present and not completing this cycle: in JRD*/JWR1/CRD1, and in IDLE with a JTAG op pending. It is 0 when no request is present.
- Reset mid-operation: FSM -> IDLE, pending cleared. RAM contents are not reset.

## Timing
- Reset values: `MonDReg=RESET_MONDREG`, `monitor_ready=0`, `jtag_overrun=0`, `avs_readdata=0`, `avs_waitrequest=0` (no request), `MonAReg=0`, FSM=IDLE.
- JTAG read: strobe in cycle 0 -> pending at edge 1 -> JRD1 in cycle 1 -> JRD2 in cycle 2. `MonDReg` and `monitor_ready=1` are valid from cycle 3.
- JTAG write: strobe in cycle 0 -> RAM updated at the end of cycle 1. `monitor_ready=1` from cycle 2.
- Both latencies add up to 1 cycle if the FSM is busy with CRD when the op is posted.
- CPU read: minimum 2 cycles (1 wait). CPU write: 0 waits when IDLE with nothing pending.
- A strobe in the same cycle as a granted IDLE CPU write: the CPU write completes, and the JTAG op starts next cycle.
- RAM is single-port, synchronous read, 1-cycle latency.

## Test plan
- JTAG write then read:
  - `take_action_ocimem_a` with `jdo[25:18]=8'h10`, `jdo[17]=0`; then `take_action_ocimem_b` with `jdo[34:3]=32'hDEADBEEF`; then `take_action_ocimem_a` with `jdo[25:18]=8'h10`, `jdo[17]=1`.
  - Expect `MonDReg=32'hDEADBEEF` 3 cycles after the last strobe, and `monitor_ready=1`.
- Auto-increment and wrap:
  - Write 8'hFF = 32'h1 and 8'h00 = 32'h2.
  - Read at 8'hFF, then issue `take_no_action_ocimem_a`.
  - Expect `MonDReg` to be 1, then 2.
- CPU byte-enable:
  - Preload 8'h20 = 32'h11223344.
  - CPU write 32'hAABBCCDD with `byteenable=4'b0101`.
  - CPU read returns 32'h11BB33DD after exactly 1 wait cycle.
- Arbitration:
  - Assert `avs_read` at 8'h20 in the same cycle as a JTAG read strobe.
  - Expect the JTAG op to complete first.
  - Expect `avs_waitrequest` to stay high through JRD2 and CRD1, with data in CRD2.
- Overrun: a second strobe 1 cycle after the first -> `jtag_overrun=1` and sticky; the first op still completes correctly.
- Reset mid-operation:
  - Assert `reset_n=0` during JRD1.
  - Expect all outputs at their reset values immediately, and a subsequent read to return the previously written RAM data.
